barrel_thread_scheduler: RTL and testbench

// Round-robin barrel scheduler feeding the fetch stage of the multithreaded RV32I core.

---
 rtl/barrel_thread_scheduler.sv | 138 +++++++++++++
 tb/tb_barrel_thread_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : barrel_thread_scheduler
// Brief   : Round-robin barrel slot generator with per-thread run state and
//           pipeline drain before idle.
// Revision: 1.0
// ============================================================================
module barrel_thread_scheduler #(
    parameter int NUM_THREADS  = 32,
    parameter int DRAIN_CYCLES = 18,
    parameter int TID_W        = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_start,
    input  logic [NUM_THREADS-1:0] host_start_mask,
    input  logic                   host_stop,
    input  logic                   halt_valid,
    input  logic [TID_W-1:0]       halt_tid,
    output logic                   issue_valid,
    output logic [TID_W-1:0]       issue_tid,
    output logic                   issue_first,
    output logic [NUM_THREADS-1:0] thread_active,
    output logic                   busy,
    output logic                   all_halted
);

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] C_DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]             r_state;
    logic [TID_W-1:0]       r_counter;
    logic [DCNT_W-1:0]      r_drain_cnt;
    logic [NUM_THREADS-1:0] r_active;
    logic [NUM_THREADS-1:0] r_first_pend;
    logic                   r_issue_valid;
    logic [TID_W-1:0]       r_issue_tid;
    logic                   r_issue_first;

    logic                   w_start_acc;
    logic                   w_stop_now;
    logic [NUM_THREADS-1:0] w_halt_vec;
    logic [NUM_THREADS-1:0] w_active_eff;
    logic                   w_issue_valid_nxt;
    logic                   w_issue_first_nxt;
    logic [1:0]             w_state_nxt;
    logic [DCNT_W-1:0]      w_drain_nxt;
    logic [NUM_THREADS-1:0] w_active_nxt;
    logic [NUM_THREADS-1:0] w_pend_nxt;

    // Same-cycle halt is folded in before slot selection so a halting thread never issues again.
    always_comb begin
        w_start_acc = (r_state == S_IDLE) && host_start && (|host_start_mask);
        w_stop_now  = (r_state == S_RUN) && host_stop;
        w_halt_vec  = '0;
        if (halt_valid && (r_state != S_IDLE)) begin
            w_halt_vec[halt_tid] = 1'b1;
        end
        w_active_eff      = r_active & ~w_halt_vec;
        w_issue_valid_nxt = (r_state == S_RUN) && !w_stop_now && w_active_eff[r_counter];
        w_issue_first_nxt = w_issue_valid_nxt && r_first_pend[r_counter];
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_nxt  = r_drain_cnt;
        w_active_nxt = w_active_eff;
        w_pend_nxt   = r_first_pend;
        case (r_state)
            S_IDLE: begin
                w_active_nxt = r_active;
                if (w_start_acc) begin
                    w_state_nxt  = S_RUN;
                    w_active_nxt = host_start_mask;
                    w_pend_nxt   = host_start_mask;
                end
            end
            S_RUN: begin
                if (w_stop_now || (w_active_eff == '0)) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = C_DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt  = S_IDLE;
                    w_active_nxt = '0;
                    w_pend_nxt   = '0;
                end else begin
                    w_drain_nxt = r_drain_cnt - DCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_active_nxt = '0;
                w_pend_nxt   = '0;
            end
        endcase
        if (w_issue_valid_nxt) begin
            w_pend_nxt[r_counter] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_counter     <= '0;
            r_drain_cnt   <= '0;
            r_active      <= '0;
            r_first_pend  <= '0;
            r_issue_valid <= 1'b0;
            r_issue_tid   <= '0;
            r_issue_first <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_counter     <= w_start_acc ? '0 : r_counter + TID_W'(1);
            r_drain_cnt   <= w_drain_nxt;
            r_active      <= w_active_nxt;
            r_first_pend  <= w_pend_nxt;
            r_issue_valid <= w_issue_valid_nxt;
            r_issue_tid   <= r_counter;
            r_issue_first <= w_issue_first_nxt;
        end
    end

    assign issue_valid   = r_issue_valid;
    assign issue_tid     = r_issue_tid;
    assign issue_first   = r_issue_first;
    assign thread_active = r_active;
    assign busy          = (r_state != S_IDLE);
    assign all_halted    = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_barrel_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_barrel_thread_scheduler
// Brief   : Directed and random checks of the barrel scheduler against a
//           cycle-level behavioural model.
// Revision: 1.0
// ============================================================================
module tb_barrel_thread_scheduler;

    localparam int NT = 32;
    localparam int DC = 18;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_start;
    logic [NT-1:0] host_start_mask;
    logic          host_stop;
    logic          halt_valid;
    logic [TW-1:0] halt_tid;
    logic          issue_valid;
    logic [TW-1:0] issue_tid;
    logic          issue_first;
    logic [NT-1:0] thread_active;
    logic          busy;
    logic          all_halted;

    barrel_thread_scheduler #(.NUM_THREADS(NT), .DRAIN_CYCLES(DC)) dut (
        .clk            (clk),
        .reset          (reset),
        .host_start     (host_start),
        .host_start_mask(host_start_mask),
        .host_stop      (host_stop),
        .halt_valid     (halt_valid),
        .halt_tid       (halt_tid),
        .issue_valid    (issue_valid),
        .issue_tid      (issue_tid),
        .issue_first    (issue_first),
        .thread_active  (thread_active),
        .busy           (busy),
        .all_halted     (all_halted)
    );

    always #5 clk = ~clk;

    // Model: 0 = idle, 1 = running, 2 = draining
    int          m_state;
    int          m_slot;
    int          m_left;
    bit [NT-1:0] m_run;
    bit [NT-1:0] m_fresh;
    bit          e_valid;
    bit          e_first;
    int          e_tid;
    int          cycle;
    int          last_iss [NT];
    int          n_cmp;
    int          n_bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic mreset();
        m_state = 0; m_slot = 0; m_left = 0; m_run = '0; m_fresh = '0;
        e_valid = 0; e_first = 0; e_tid = 0;
        for (int i = 0; i < NT; i++) last_iss[i] = -1;
    endtask

    task automatic model_step();
        bit [NT-1:0] alive;
        int          slot;
        if (reset) begin
            mreset();
            return;
        end
        slot  = m_slot;
        alive = m_run;
        if (halt_valid && m_state != 0) alive[halt_tid] = 1'b0;
        e_tid   = slot;
        e_valid = (m_state == 1) && !host_stop && alive[slot];
        e_first = e_valid && m_fresh[slot];
        if (e_valid) m_fresh[slot] = 1'b0;
        m_slot = (m_slot + 1) % NT;
        if (m_state == 0) begin
            if (host_start && host_start_mask != '0) begin
                m_state = 1; m_run = host_start_mask; m_fresh = host_start_mask; m_slot = 0;
                for (int i = 0; i < NT; i++) last_iss[i] = -1;
            end
        end else if (m_state == 1) begin
            m_run = alive;
            if (host_stop || alive == '0) begin
                m_state = 2; m_left = DC;
            end
        end else begin
            m_run  = alive;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_state = 0; m_run = '0; m_fresh = '0;
            end
        end
    endtask

    task automatic check_all();
        chk("issue_valid", 64'(issue_valid), 64'(e_valid));
        chk("issue_tid", 64'(issue_tid), 64'(e_tid));
        chk("issue_first", 64'(issue_first), 64'(e_first));
        chk("thread_active", 64'(thread_active), 64'(m_run));
        chk("busy", 64'(busy), 64'(m_state != 0));
        chk("all_halted", 64'(all_halted), 64'(m_state == 0));
        if (issue_valid) begin
            n_cmp++;
            if (last_iss[issue_tid] >= 0 && cycle - last_iss[issue_tid] < NT) begin
                n_bad++;
                $display("FAIL barrel_gap: tid %0d gap %0d expected >= %0d", issue_tid,
                         cycle - last_iss[issue_tid], NT);
            end
            last_iss[issue_tid] = cycle;
        end
    endtask

    task automatic cyc(input bit st, input logic [NT-1:0] mk, input bit sp,
                       input bit hv, input logic [TW-1:0] ht);
        @(negedge clk);
        host_start = st; host_start_mask = mk; host_stop = sp; halt_valid = hv; halt_tid = ht;
        @(posedge clk);
        model_step();
        #1;
        cycle++;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, '0);
    endtask

    // Called between edges: asserts reset asynchronously, holds it two edges, releases mid-cycle.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        mreset();
        check_all();
        cyc(0, '0, 0, 0, '0);
        cyc(0, '0, 0, 0, '0);
        reset = 1'b0;
    endtask

    task automatic count_drain(input string name);
        int n;
        int v;
        n = 0; v = 0;
        while (busy && n < 40) begin
            n++;
            v += int'(issue_valid);
            cyc(0, '0, 0, 0, '0);
        end
        chk({name, "_len"}, 64'(n), 64'(DC));
        chk({name, "_no_issue"}, 64'(v), 64'(0));
    endtask

    initial begin
        int nv;
        int nf;
        int n7;
        int guard;
        logic [NT-1:0] mk;
        n_cmp = 0; n_bad = 0; cycle = 0;
        reset = 1'b1; host_start = 0; host_start_mask = '0; host_stop = 0; halt_valid = 0; halt_tid = '0;
        #1;
        mreset();
        chk("rst_valid", 64'(issue_valid), 64'(0));
        chk("rst_tid", 64'(issue_tid), 64'(0));
        chk("rst_first", 64'(issue_first), 64'(0));
        chk("rst_active", 64'(thread_active), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_halted", 64'(all_halted), 64'(1));
        cyc(0, '0, 0, 0, '0);
        reset = 1'b0;

        // Idle: stop and halt noise must be ignored, slot keeps rotating
        for (int i = 0; i < 100; i++) cyc(0, '0, ($urandom % 4) == 0, ($urandom % 4) == 0, TW'($urandom));
        chk("idle_tid_wrap", 64'(issue_tid), 64'(99 % NT));
        chk("idle_halted", 64'(all_halted), 64'(1));

        // All threads: 32 consecutive first issues
        cyc(1, '1, 0, 0, '0);
        nv = 0; nf = 0;
        for (int i = 0; i < NT; i++) begin
            cyc(0, '0, 0, 0, '0);
            nv += int'(issue_valid);
            nf += int'(issue_first);
            if (i == 5) chk("all_tid5", 64'(issue_tid), 64'(5));
        end
        chk("all_valid_cnt", 64'(nv), 64'(NT));
        chk("all_first_cnt", 64'(nf), 64'(NT));
        nf = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, '0, 0, 0, '0);
            nf += int'(issue_first);
        end
        chk("all_first_after", 64'(nf), 64'(0));
        // Stop with a simultaneous start: start ignored, full drain
        cyc(1, 32'h1, 1, 0, '0);
        count_drain("stop_drain");
        chk("stop_idle", 64'(all_halted), 64'(1));

        // Sparse mask 0 and 2
        cyc(1, 32'h5, 0, 0, '0);
        nv = 0;
        for (int i = 0; i < 2 * NT; i++) begin
            cyc(0, '0, 0, 0, '0);
            nv += int'(issue_valid);
        end
        chk("mask5_cnt", 64'(nv), 64'(4));
        cyc(0, '0, 0, 1, 5'd2);
        nv = 0;
        for (int i = 0; i < 2 * NT; i++) begin
            cyc(0, '0, 0, 0, '0);
            nv += int'(issue_valid);
            if (issue_valid) chk("mask5_only_t0", 64'(issue_tid), 64'(0));
        end
        chk("mask5_t0_cnt", 64'(nv), 64'(2));
        cyc(0, '0, 0, 1, 5'd0);
        count_drain("halt_drain");
        chk("halt_idle_active", 64'(thread_active), 64'(0));
        chk("halt_idle_flag", 64'(all_halted), 64'(1));

        // Halt tid 7 in its own slot cycle
        cyc(1, '1, 0, 0, '0);
        guard = 0;
        while (m_slot != 7 && guard < 40) begin
            cyc(0, '0, 0, 0, '0);
            guard++;
        end
        chk("slot7_reached", 64'(m_slot), 64'(7));
        cyc(0, '0, 0, 1, 5'd7);
        chk("h7_tid", 64'(issue_tid), 64'(7));
        chk("h7_valid", 64'(issue_valid), 64'(0));
        chk("h7_active", 64'(thread_active[7]), 64'(0));
        n7 = 0;
        for (int i = 0; i < 2 * NT; i++) begin
            cyc(0, '0, 0, 0, '0);
            n7 += int'(issue_valid && issue_tid == 5'd7);
        end
        chk("h7_never", 64'(n7), 64'(0));

        // Reset mid-drain, then restart with thread 0 only
        cyc(0, '0, 1, 0, '0);
        idle_cycles(5);
        chk("mid_drain_busy", 64'(busy), 64'(1));
        async_reset();
        chk("post_rst_active", 64'(thread_active), 64'(0));
        chk("post_rst_halted", 64'(all_halted), 64'(1));
        cyc(1, 32'h1, 0, 0, '0);
        cyc(0, '0, 0, 0, '0);
        chk("restart_tid", 64'(issue_tid), 64'(0));
        chk("restart_valid", 64'(issue_valid), 64'(1));
        chk("restart_first", 64'(issue_first), 64'(1));

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            case ($urandom % 4)
                0: mk = '0;
                1: mk = NT'($urandom);
                2: mk = NT'(1) << ($urandom % NT);
                default: mk = '1;
            endcase
            if (($urandom % 1500) == 0) async_reset();
            cyc(($urandom % 8) == 0, mk, ($urandom % 150) == 0, ($urandom % 12) == 0, TW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
